cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) between the two result producers, the ALU issue path and the load/store buffer. Each producer gets a small per-source FIFO. A round-robin grant places at most one result per cycle on the registered CDB. The reservation station, LSB and ROB snoop the CDB. The block sits between the execution units and those snoopers, and is flushed by the ROB `clear` on mispredict.

---
 rtl/cdb_pkg.sv | 17 +
 rtl/cdb_src_fifo.sv | 58 +++++
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and default widths for the common data bus arbiter and its snoopers.
package cdb_pkg;

  localparam int TAG_W = 5;
  localparam int VAL_W = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] val;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: DEPTH-entry circular buffer with wrapping head/tail pointers.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The owner never pushes while full nor pops while empty; flush wins over both.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing ALU / LSB results onto the registered common data bus.
// Optional performance counters are enabled by defining CDB_ARB_PERF_EN.
module cdb_arbiter #(
  parameter int DEPTH = 2,
  parameter int TAG_W = cdb_pkg::TAG_W,
  parameter int VAL_W = cdb_pkg::VAL_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [VAL_W-1:0] alu_val,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [VAL_W-1:0] lsb_val,
  output logic             alu_full,
  output logic             lsb_full,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [VAL_W-1:0] cdb_val,
  output logic             cdb_src
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]      perf_alu_cnt,
  output logic [31:0]      perf_lsb_cnt,
  output logic [31:0]      perf_conflict_cnt,
  output logic             perf_overflow
`endif
);

  import cdb_pkg::*;

  localparam int EW = TAG_W + VAL_W;

  // Handshake: a producer asserts *_valid for one cycle per result and may only do so
  // while its *_full is low; a push seen with *_full high or tag 0 is discarded.
  logic          active;
  logic          alu_push_ok, lsb_push_ok;
  logic          alu_empty, lsb_empty;
  logic [EW-1:0] alu_head, lsb_head;
  logic          alu_cand_v, lsb_cand_v;
  logic [EW-1:0] alu_cand, lsb_cand;
  logic          both_cand;
  logic          grant_v;
  logic          grant_lsb;
  logic          alu_pop, lsb_pop;
  logic          alu_enq, lsb_enq;
  logic [EW-1:0] win_entry;

  cdb_src_e last_grant;
  cdb_src_e src_q;

  assign active = rdy_in && !clear;

  assign alu_push_ok = active && alu_valid && (alu_tag != '0) && !alu_full;
  assign lsb_push_ok = active && lsb_valid && (lsb_tag != '0) && !lsb_full;

  // An empty FIFO offers the incoming push directly (bypass).
  assign alu_cand_v = !alu_empty || alu_push_ok;
  assign lsb_cand_v = !lsb_empty || lsb_push_ok;
  assign alu_cand   = alu_empty ? {alu_tag, alu_val} : alu_head;
  assign lsb_cand   = lsb_empty ? {lsb_tag, lsb_val} : lsb_head;

  assign both_cand = alu_cand_v && lsb_cand_v;
  assign grant_v   = active && (alu_cand_v || lsb_cand_v);
  assign grant_lsb = both_cand ? (last_grant == SRC_ALU) : lsb_cand_v;
  assign win_entry = grant_lsb ? lsb_cand : alu_cand;

  assign alu_pop = grant_v && !grant_lsb && !alu_empty;
  assign lsb_pop = grant_v &&  grant_lsb && !lsb_empty;

  // A push goes into its FIFO unless it rode the bypass straight onto the bus.
  assign alu_enq = alu_push_ok && (!alu_empty ||  grant_lsb);
  assign lsb_enq = lsb_push_ok && (!lsb_empty || !grant_lsb);

  cdb_src_fifo #(.DEPTH(DEPTH), .W(EW)) u_alu_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (clear),
    .push   (alu_enq),
    .pop    (alu_pop),
    .din    ({alu_tag, alu_val}),
    .head   (alu_head),
    .empty  (alu_empty),
    .full   (alu_full)
  );

  cdb_src_fifo #(.DEPTH(DEPTH), .W(EW)) u_lsb_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (clear),
    .push   (lsb_enq),
    .pop    (lsb_pop),
    .din    ({lsb_tag, lsb_val}),
    .head   (lsb_head),
    .empty  (lsb_empty),
    .full   (lsb_full)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_val    <= '0;
      src_q      <= SRC_ALU;
      last_grant <= SRC_LSB;
    end else if (clear) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_val    <= '0;
      src_q      <= SRC_ALU;
      last_grant <= SRC_LSB;
    end else if (rdy_in) begin
      if (grant_v) begin
        cdb_valid  <= 1'b1;
        cdb_tag    <= win_entry[EW-1:VAL_W];
        cdb_val    <= win_entry[VAL_W-1:0];
        src_q      <= grant_lsb ? SRC_LSB : SRC_ALU;
        last_grant <= grant_lsb ? SRC_LSB : SRC_ALU;
      end else begin
        // Zero tag on idle so no snooper compare can hit.
        cdb_valid  <= 1'b0;
        cdb_tag    <= '0;
        cdb_val    <= '0;
        src_q      <= SRC_ALU;
      end
    end
  end

  assign cdb_src = src_q;

`ifdef CDB_ARB_PERF_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_alu_cnt      <= '0;
      perf_lsb_cnt      <= '0;
      perf_conflict_cnt <= '0;
      perf_overflow     <= 1'b0;
    end else if (active) begin
      if (grant_v && !grant_lsb) perf_alu_cnt <= perf_alu_cnt + 32'd1;
      if (grant_v &&  grant_lsb) perf_lsb_cnt <= perf_lsb_cnt + 32'd1;
      if (both_cand)             perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if ((alu_valid && alu_full) || (lsb_valid && lsb_full)) perf_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; perf outputs are checked when CDB_ARB_PERF_EN is defined.
module tb_cdb_arbiter;

  localparam int TAG_W = 5;
  localparam int VAL_W = 32;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             clear;
  logic             alu_valid;
  logic [TAG_W-1:0] alu_tag;
  logic [VAL_W-1:0] alu_val;
  logic             lsb_valid;
  logic [TAG_W-1:0] lsb_tag;
  logic [VAL_W-1:0] lsb_val;
  logic             alu_full;
  logic             lsb_full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [VAL_W-1:0] cdb_val;
  logic             cdb_src;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]      perf_alu_cnt;
  logic [31:0]      perf_lsb_cnt;
  logic [31:0]      perf_conflict_cnt;
  logic             perf_overflow;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [TAG_W-1:0] exp_q[$];

  cdb_arbiter #(.DEPTH(2), .TAG_W(TAG_W), .VAL_W(VAL_W)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clear             (clear),
    .alu_valid         (alu_valid),
    .alu_tag           (alu_tag),
    .alu_val           (alu_val),
    .lsb_valid         (lsb_valid),
    .lsb_tag           (lsb_tag),
    .lsb_val           (lsb_val),
    .alu_full          (alu_full),
    .lsb_full          (lsb_full),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_val           (cdb_val),
    .cdb_src           (cdb_src)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_alu_cnt      (perf_alu_cnt),
    .perf_lsb_cnt      (perf_lsb_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_overflow     (perf_overflow)
`endif
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic av, input logic [TAG_W-1:0] at,
                       input logic lv, input logic [TAG_W-1:0] lt);
    alu_valid = av;
    alu_tag   = at;
    alu_val   = 32'hA000 + 32'(at);
    lsb_valid = lv;
    lsb_tag   = lt;
    lsb_val   = 32'hB000 + 32'(lt);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  // scoreboard checks
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic expect_bus(input string name, input logic v, input logic [TAG_W-1:0] t,
                            input logic s);
    logic [VAL_W-1:0] ev;
    ev = !v ? '0 : (s ? 32'hB000 + 32'(t) : 32'hA000 + 32'(t));
    check({name, ".valid"}, 64'(cdb_valid), 64'(v));
    check({name, ".tag"},   64'(cdb_tag),   64'(v ? t : '0));
    check({name, ".val"},   64'(cdb_val),   64'(ev));
    if (v) check({name, ".src"}, 64'(cdb_src), 64'(s));
  endtask

  initial begin
    int na;
    int nl;
    logic av;
    logic lv;
    logic [TAG_W-1:0] et;

    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear  = 1'b0;
    idle();
    step();
    step();
    expect_bus("reset", 1'b0, '0, 1'b0);
    check("reset.src", 64'(cdb_src), 64'd0);
    check("reset.alu_full", 64'(alu_full), 64'd0);
    check("reset.lsb_full", 64'(lsb_full), 64'd0);
`ifdef CDB_ARB_PERF_EN
    check("reset.perf_alu", 64'(perf_alu_cnt), 64'd0);
    check("reset.perf_ovf", 64'(perf_overflow), 64'd0);
`endif
    rst_in = 1'b0;

    // single ALU push through the bypass
    drive(1'b1, 5'd3, 1'b0, '0);
    step();
    idle();
    expect_bus("alu_single", 1'b1, 5'd3, 1'b0);
    step();
    expect_bus("alu_single_after", 1'b0, '0, 1'b0);

    // simultaneous push right after reset: ALU first
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 5'd2);
    step();
    idle();
    expect_bus("dual_first", 1'b1, 5'd1, 1'b0);
    check("dual_first.alu_full", 64'(alu_full), 64'd0);
    check("dual_first.lsb_full", 64'(lsb_full), 64'd0);
    step();
    expect_bus("dual_second", 1'b1, 5'd2, 1'b1);
    check("dual_second.lsb_full", 64'(lsb_full), 64'd0);
    step();
    expect_bus("dual_idle", 1'b0, '0, 1'b0);

    // continuous dual push, producers honouring *_full
    exp_q = {5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14,
             5'd5, 5'd15, 5'd6, 5'd16, 5'd7, 5'd17, 5'd8, 5'd18};
    na = 1;
    nl = 11;
    for (int i = 0; i < 16; i++) begin
      av = (na <= 8) && !alu_full;
      lv = (nl <= 18) && !lsb_full;
      drive(av, TAG_W'(na), lv, TAG_W'(nl));
      if (av) na++;
      if (lv) nl++;
      step();
      et = exp_q.pop_front();
      expect_bus($sformatf("stream%0d", i), 1'b1, et, et > 5'd10);
      if (i == 2) begin
        check("stream2.lsb_full", 64'(lsb_full), 64'd1);
        check("stream2.alu_full", 64'(alu_full), 64'd0);
      end
      if (i == 3) check("stream3.alu_full", 64'(alu_full), 64'd1);
    end
    idle();
    step();
    expect_bus("stream_drained", 1'b0, '0, 1'b0);

    // clear with queued entries
    drive(1'b1, 5'd21, 1'b1, 5'd22);
    step();
    expect_bus("clr_fill0", 1'b1, 5'd21, 1'b0);
    drive(1'b1, 5'd23, 1'b1, 5'd24);
    step();
    expect_bus("clr_fill1", 1'b1, 5'd22, 1'b1);
    drive(1'b1, 5'd25, 1'b1, 5'd26);
    step();
    expect_bus("clr_fill2", 1'b1, 5'd23, 1'b0);
    check("clr_fill2.lsb_full", 64'(lsb_full), 64'd1);
    drive(1'b1, 5'd27, 1'b0, '0);
    step();
    expect_bus("clr_fill3", 1'b1, 5'd24, 1'b1);
    check("clr_fill3.alu_full", 64'(alu_full), 64'd1);
    drive(1'b0, '0, 1'b1, 5'd28);
    step();
    expect_bus("clr_fill4", 1'b1, 5'd25, 1'b0);
    check("clr_fill4.lsb_full", 64'(lsb_full), 64'd1);
    clear = 1'b1;
    drive(1'b1, 5'd31, 1'b0, '0);
    step();
    clear = 1'b0;
    idle();
    expect_bus("clr_cycle", 1'b0, '0, 1'b0);
    check("clr_cycle.alu_full", 64'(alu_full), 64'd0);
    check("clr_cycle.lsb_full", 64'(lsb_full), 64'd0);
    step();
    expect_bus("clr_quiet0", 1'b0, '0, 1'b0);
    step();
    expect_bus("clr_quiet1", 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 5'd5);
    step();
    idle();
    expect_bus("clr_new_lsb", 1'b1, 5'd5, 1'b1);
    step();
    expect_bus("clr_new_after", 1'b0, '0, 1'b0);

    // clear returns round-robin priority to the ALU
    drive(1'b1, 5'd12, 1'b0, '0);
    step();
    idle();
    expect_bus("rr_alu", 1'b1, 5'd12, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    expect_bus("rr_clear", 1'b0, '0, 1'b0);
    drive(1'b1, 5'd14, 1'b1, 5'd15);
    step();
    idle();
    expect_bus("rr_first", 1'b1, 5'd14, 1'b0);
    step();
    expect_bus("rr_second", 1'b1, 5'd15, 1'b1);

    // rdy_in low holds bus and queues, ignores pushes
    drive(1'b1, 5'd4, 1'b1, 5'd9);
    step();
    expect_bus("rdy_pre", 1'b1, 5'd4, 1'b0);
    rdy_in = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 5'd11);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_bus($sformatf("rdy_hold%0d", i), 1'b1, 5'd4, 1'b0);
    end
    rdy_in = 1'b1;
    idle();
    step();
    expect_bus("rdy_resume", 1'b1, 5'd9, 1'b1);
    step();
    expect_bus("rdy_empty", 1'b0, '0, 1'b0);

    // tag 0 push is dropped
    drive(1'b1, '0, 1'b0, '0);
    step();
    idle();
    expect_bus("tag0_drop", 1'b0, '0, 1'b0);

    // push while full is dropped
    drive(1'b1, 5'd16, 1'b1, 5'd17);
    step();
    expect_bus("ovf0", 1'b1, 5'd16, 1'b0);
    drive(1'b1, 5'd18, 1'b1, 5'd19);
    step();
    expect_bus("ovf1", 1'b1, 5'd17, 1'b1);
    drive(1'b1, 5'd20, 1'b1, 5'd21);
    step();
    expect_bus("ovf2", 1'b1, 5'd18, 1'b0);
    check("ovf2.lsb_full", 64'(lsb_full), 64'd1);
    drive(1'b0, '0, 1'b1, 5'd22);
    step();
    idle();
    expect_bus("ovf3", 1'b1, 5'd19, 1'b1);
`ifdef CDB_ARB_PERF_EN
    check("ovf3.perf_ovf", 64'(perf_overflow), 64'd1);
`endif
    step();
    expect_bus("ovf4", 1'b1, 5'd20, 1'b0);
    step();
    expect_bus("ovf5", 1'b1, 5'd21, 1'b1);
    step();
    expect_bus("ovf_drained", 1'b0, '0, 1'b0);
`ifdef CDB_ARB_PERF_EN
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("perf.ovf_after_clear", 64'(perf_overflow), 64'd1);
    check("perf.conflict_ge6", 64'(perf_conflict_cnt >= 32'd6), 64'd1);
`endif

    // asynchronous reset mid-broadcast
    drive(1'b1, 5'd3, 1'b0, '0);
    step();
    idle();
    expect_bus("async_pre", 1'b1, 5'd3, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    expect_bus("async_rst", 1'b0, '0, 1'b0);
    check("async_rst.src", 64'(cdb_src), 64'd0);
`ifdef CDB_ARB_PERF_EN
    check("async_rst.perf_ovf", 64'(perf_overflow), 64'd0);
`endif
    #1;
    rst_in = 1'b0;

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
